led_frame_sched: RTL and testbench
==================================

LED_FRAME_SCHED -- requirements
Module: led_frame_sched

Interface
REQ-001 The block SHALL have parameter c_freq, default 20000000, system clock frequency in Hz (documentation and derivation only).
REQ-002 The block SHALL have parameter c_bits, default 128, frame width in bits.
REQ-003 The block SHALL have parameter c_div, default 10, system clocks per o_clk half-period (minimum 1).
REQ-004 The block SHALL have parameter c_gap, default 4, system clocks of idle o_clk between the last bit and latch (minimum 1).
REQ-005 The block SHALL have parameter c_lat, default 2, system clocks o_lat is held high (minimum 1).
REQ-006 The block SHALL have parameter c_refresh, default 2000000, idle system clocks before the last frame is retransmitted.
REQ-007 The block SHALL have port i_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-008 The block SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-009 The block SHALL have port i_data, input, c_bits, frame from the SPI receive path.
REQ-010 The block SHALL have port i_valid, input, 1, i_data is valid.
REQ-011 The block SHALL have port o_ready, output, 1, pending buffer can accept a frame.
REQ-012 The block SHALL have port o_clk, output, 1, LED driver shift clock.
REQ-013 The block SHALL have port o_dai, output, 1, LED driver serial data.
REQ-014 The block SHALL have port o_lat, output, 1, LED driver latch pulse.
REQ-015 The block SHALL have port o_busy, output, 1, high in any state other than IDLE.

Function
REQ-016 A frame SHALL be accepted on a cycle where i_valid and o_ready are both high; the pending buffer then becomes full and o_ready goes low on the next cycle.
REQ-017 i_valid while o_ready is low SHALL be ignored; the producer holds the frame.
REQ-018 The state machine SHALL have states IDLE, LOAD, SHIFT, GAP and LATCH.
REQ-019 IDLE with the pending buffer full SHALL go to LOAD, which copies pending to the active and shift registers, empties pending (o_ready high next cycle) and enters SHIFT.
REQ-020 In SHIFT, each bit SHALL take 2*c_div cycles: o_clk low for c_div cycles with o_dai valid, then o_clk high for c_div cycles; bits go MSB first; o_dai changes only while o_clk is low.
REQ-021 The first o_clk rising edge SHALL occur exactly c_div+1 cycles after LOAD.
REQ-022 After c_bits rising edges, GAP SHALL hold o_clk and o_dai low for c_gap cycles.
REQ-023 LATCH SHALL then drive o_lat high for exactly c_lat cycles and return to IDLE.
REQ-024 In IDLE, a refresh counter SHALL count to c_refresh, then reload the active frame into the shift register and enter SHIFT; the counter clears on every entry to IDLE.
REQ-025 Refresh SHALL NOT occur until at least one frame has been accepted since reset.
REQ-026 If the pending buffer is full on the same cycle the refresh counter expires, the new frame SHALL win and refresh is cancelled.
REQ-027 Frames accepted during SHIFT, GAP or LATCH SHALL NOT alter the frame in flight; a later accept overwrites nothing because o_ready is low.
REQ-028 Bit, divider and refresh counters SHALL be sized with $clog2 of their terminal values and SHALL saturate at the terminal count without wrap-around.

Reset
REQ-029 Asserting i_rst_n low SHALL at any time, including mid-SHIFT or mid-LATCH, immediately force o_clk=0, o_dai=0, o_lat=0, o_busy=0, o_ready=1, state IDLE, all counters 0, pending empty and the frame-seen flag cleared.

Structure
REQ-030 State encodings and default timing constants SHALL live in shared package led_pkg.
REQ-031 The o_clk half-period tick generator SHALL be a sub-module, led_clk_div, parameterised by c_div.

Verification
REQ-032 With c_bits=16, c_div=2, c_gap=4, c_lat=2, sending 16'hA5C3 SHALL produce 16 o_clk rises with o_dai sampled 1010010111000011, then 4 idle cycles, then o_lat high for exactly 2 cycles.
REQ-033 After a single accept with c_refresh=1000 and no further input, the identical frame SHALL be retransmitted starting 1000 cycles after return to IDLE, repeating.
REQ-034 Two back-to-back frames 16'h0001 then 16'hFFFF SHALL show o_ready low after the second until LOAD of the first frame's successor, and both frames shifted in order with no corruption.
REQ-035 Pulsing i_rst_n low at the 7th bit of SHIFT SHALL force all outputs low and o_ready high within the same cycle, with no refresh afterwards until a new accept.
REQ-036 A frame presented on the exact cycle the refresh counter reaches c_refresh SHALL be the one shifted; the old frame SHALL not appear.

Source files
------------

// File: rtl/led_pkg.sv
// Shared state encoding, default timing constants and counter sizing helper
// for the LED frame scheduler.
package led_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_LATCH = 3'd4
  } led_state_t;

  localparam int LED_FREQ       = 20000000;
  localparam int LED_BITS       = 128;
  localparam int LED_DIV        = 10;
  localparam int LED_GAP        = 4;
  localparam int LED_LAT        = 2;
  // Retransmit rate: one refresh every 100 ms at the default clock.
  localparam int LED_REFRESH_HZ = 10;

  // Bits needed to hold counts 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_clk_div.sv
// Half-period tick generator for the LED shift clock: o_tick pulses on the
// last system clock of every c_div-cycle half-period while enabled.
module led_clk_div
  import led_pkg::*;
#(
  parameter int c_div = LED_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int              c_w    = cnt_w(c_div);
  localparam logic [c_w-1:0]  c_last = c_w'(c_div - 1);

  logic [c_w-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == c_last);

  // Dropping the enable restarts the half-period from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_frame_sched.sv
// LED driver frame scheduler: buffers one frame, shifts it MSB first on
// o_clk/o_dai, latches it, and periodically retransmits the last frame.
module led_frame_sched
  import led_pkg::*;
#(
  parameter int c_freq    = LED_FREQ,
  parameter int c_bits    = LED_BITS,
  parameter int c_div     = LED_DIV,
  parameter int c_gap     = LED_GAP,
  parameter int c_lat     = LED_LAT,
  parameter int c_refresh = c_freq / LED_REFRESH_HZ
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [c_bits-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_clk,
  output logic              o_dai,
  output logic              o_lat,
  output logic              o_busy
);

  localparam int c_bit_w    = cnt_w(c_bits);
  localparam int c_tail_max = (c_gap > c_lat) ? c_gap : c_lat;
  localparam int c_tail_w   = cnt_w(c_tail_max);
  localparam int c_ref_w    = cnt_w(c_refresh + 1);

  localparam logic [c_bit_w-1:0]  c_bit_last = c_bit_w'(c_bits - 1);
  localparam logic [c_tail_w-1:0] c_gap_last = c_tail_w'(c_gap - 1);
  localparam logic [c_tail_w-1:0] c_lat_last = c_tail_w'(c_lat - 1);
  localparam logic [c_ref_w-1:0]  c_ref_max  = c_ref_w'(c_refresh);
  localparam logic [c_ref_w-1:0]  c_ref_last = c_ref_w'(c_refresh - 1);

  led_state_t          r_state;
  led_state_t          w_next;
  logic [c_bits-1:0]   r_pend;
  logic [c_bits-1:0]   r_active;
  logic [c_bits-1:0]   r_shift;
  logic                r_pend_full;
  logic                r_seen;
  logic                r_phase;
  logic [c_bit_w-1:0]  r_bit;
  logic [c_tail_w-1:0] r_cnt;
  logic [c_ref_w-1:0]  r_ref;

  logic w_accept;
  logic w_tick;
  logic w_last_bit;
  logic w_bit_end;
  logic w_in_tail;
  logic w_tail_done;
  logic w_ref_hit;
  logic w_refresh;

  led_clk_div #(
    .c_div (c_div)
  ) u_clk_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (r_state == ST_SHIFT),
    .o_tick  (w_tick)
  );

  assign w_accept    = i_valid && !r_pend_full;
  assign w_last_bit  = (r_bit == c_bit_last);
  assign w_bit_end   = (r_state == ST_SHIFT) && w_tick && r_phase;
  assign w_in_tail   = (r_state == ST_GAP) || (r_state == ST_LATCH);
  assign w_tail_done = ((r_state == ST_GAP)   && (r_cnt == c_gap_last)) ||
                       ((r_state == ST_LATCH) && (r_cnt == c_lat_last));
  // Refresh fires on the c_refresh-th idle cycle, once a frame has been seen.
  assign w_ref_hit   = r_seen && (r_ref == c_ref_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A frame arriving on the expiry cycle cancels the refresh; it loads next.
  always_comb begin
    w_next    = r_state;
    w_refresh = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_pend_full) begin
          w_next = ST_LOAD;
        end else if (w_ref_hit && !w_accept) begin
          w_next    = ST_SHIFT;
          w_refresh = 1'b1;
        end
      end
      ST_LOAD:  w_next = ST_SHIFT;
      ST_SHIFT: if (w_bit_end && w_last_bit) w_next = ST_GAP;
      ST_GAP:   if (w_tail_done) w_next = ST_LATCH;
      ST_LATCH: if (w_tail_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_full <= 1'b0;
      r_seen      <= 1'b0;
      r_phase     <= 1'b0;
      r_bit       <= '0;
      r_cnt       <= '0;
      r_ref       <= '0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend_full <= 1'b1;
      end

      if (w_accept) begin
        r_seen <= 1'b1;
      end

      if (r_state != ST_SHIFT) begin
        r_phase <= 1'b0;
        r_bit   <= '0;
      end else if (w_tick) begin
        r_phase <= ~r_phase;
        if (r_phase && !w_last_bit) begin
          r_bit <= r_bit + 1'b1;
        end
      end

      if (w_in_tail && !w_tail_done) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end

      // Held at zero outside IDLE, so every entry to IDLE starts a fresh count.
      if (r_state != ST_IDLE) begin
        r_ref <= '0;
      end else if (r_ref != c_ref_max) begin
        r_ref <= r_ref + 1'b1;
      end
    end
  end

  // Frame storage carries no reset; the outputs are gated by state instead.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_pend <= i_data;
    end
    if (r_state == ST_LOAD) begin
      r_active <= r_pend;
      r_shift  <= r_pend;
    end else if (w_refresh) begin
      r_shift <= r_active;
    end else if (w_bit_end) begin
      r_shift <= r_shift << 1;
    end
  end

  assign o_ready = !r_pend_full;
  assign o_clk   = (r_state == ST_SHIFT) && r_phase;
  assign o_dai   = (r_state == ST_SHIFT) && r_shift[c_bits-1];
  assign o_lat   = (r_state == ST_LATCH);
  assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_led_frame_sched.sv
// Bench for led_frame_sched: frames are captured from the pins and compared
// against a transaction-level expectation built from the timing rules.
module tb_led_frame_sched;

  localparam int P_BITS   = 16;
  localparam int P_DIV    = 2;
  localparam int P_GAP    = 4;
  localparam int P_LAT    = 2;
  localparam int P_REF    = 1000;
  localparam int P_FRAME  = 2 * P_DIV * P_BITS + P_GAP + P_LAT;
  localparam int P_BUDGET = P_FRAME + 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data  = '0;
  logic        o_ready, o_clk, o_dai, o_lat, o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        found;
    logic [7:0]  rises;
    logic [15:0] bits;
    logic [7:0]  first_rise;
    logic [7:0]  gap;
    logic [7:0]  lat;
    logic        tail_ok;
    logic        glitch;
  } obs_t;

  always #5 clk = ~clk;

  led_frame_sched #(
    .c_freq    (1000000),
    .c_bits    (P_BITS),
    .c_div     (P_DIV),
    .c_gap     (P_GAP),
    .c_lat     (P_LAT),
    .c_refresh (P_REF)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data),
    .i_valid (valid),
    .o_ready (o_ready),
    .o_clk   (o_clk),
    .o_dai   (o_dai),
    .o_lat   (o_lat),
    .o_busy  (o_busy)
  );

  // What a correct transmission of d looks like on the pins.
  function automatic obs_t expect_frame(input logic [15:0] d, input int first);
    obs_t e;
    e.found      = 1'b1;
    e.rises      = 8'(P_BITS);
    e.bits       = d;
    e.first_rise = 8'(first);
    e.gap        = 8'(P_GAP);
    e.lat        = 8'(P_LAT);
    e.tail_ok    = 1'b1;
    e.glitch     = 1'b0;
    return e;
  endfunction

  function automatic string obs_str(input obs_t o);
    return $sformatf("found=%0d rises=%0d bits=%h first_rise=%0d gap=%0d lat=%0d tail=%0d glitch=%0d",
                     o.found, o.rises, o.bits, o.first_rise, o.gap, o.lat, o.tail_ok, o.glitch);
  endfunction

  // Records one busy period from the pins (index 0 = first busy cycle) and
  // returns its measured properties. Called at a negedge; returns at the
  // negedge of the first idle cycle after it.
  task automatic capture(output obs_t o);
    logic s_clk [0:511];
    logic s_dai [0:511];
    logic s_lat [0:511];
    int   n, w, last_hi, first_lat, last_lat, rises;
    o = '0;
    w = 0;
    while (!o_busy && w < 4 * P_REF) begin
      @(negedge clk);
      w++;
    end
    if (!o_busy) return;
    n = 0;
    while (o_busy && n < P_BUDGET) begin
      s_clk[n] = o_clk;
      s_dai[n] = o_dai;
      s_lat[n] = o_lat;
      n++;
      @(negedge clk);
    end
    o.found   = !o_busy;
    last_hi   = -1;
    first_lat = -1;
    last_lat  = -1;
    rises     = 0;
    for (int k = 0; k < n; k++) begin
      if (s_clk[k] && (k == 0 || !s_clk[k-1])) begin
        rises++;
        if (rises == 1) o.first_rise = 8'(k);
        o.bits = {o.bits[14:0], s_dai[k]};
      end
      if (s_clk[k] && k > 0 && s_clk[k-1] && s_dai[k] != s_dai[k-1]) o.glitch = 1'b1;
      if (s_clk[k]) last_hi = k;
      if (s_lat[k]) begin
        if (first_lat >= 0 && k != last_lat + 1) o.glitch = 1'b1;
        if (first_lat < 0) first_lat = k;
        if (s_clk[k] || s_dai[k]) o.glitch = 1'b1;
        last_lat = k;
        o.lat    = o.lat + 8'd1;
      end
    end
    for (int k = last_hi + 1; k < first_lat; k++) begin
      if (s_dai[k] || s_lat[k]) o.glitch = 1'b1;
    end
    o.rises   = 8'(rises);
    if (first_lat >= 0) o.gap = 8'(first_lat - last_hi - 1);
    o.tail_ok = o.found && (last_lat == n - 1);
  endtask

  // Presents d from a negedge until accepted; returns at the next negedge.
  task automatic send(input logic [15:0] d);
    int w;
    w     = 0;
    data  = d;
    valid = 1'b1;
    while (!o_ready && w < 2 * P_BUDGET) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: o_ready=%b after %0d cycles, required 1", o_ready, w);
    end
    @(negedge clk);
    valid = 1'b0;
    data  = 16'($urandom);
  endtask

  task automatic test_reset();
    int hi;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({o_clk, o_dai, o_lat, o_busy, o_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_held: clk/dai/lat/busy/ready=%b, required 00001",
               {o_clk, o_dai, o_lat, o_busy, o_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_clk, o_dai, o_lat, o_busy, o_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_released: clk/dai/lat/busy/ready=%b, required 00001",
               {o_clk, o_dai, o_lat, o_busy, o_ready});
    end
    hi = 0;
    for (int i = 0; i < P_REF + 50; i++) begin
      @(negedge clk);
      if (o_busy) hi++;
    end
    n_cmp++;
    if (hi !== 0) begin
      n_bad++;
      $display("FAIL no_refresh_before_accept: busy cycles=%0d, required 0", hi);
    end
  endtask

  task automatic test_single_frame();
    obs_t o, e;
    send(16'hA5C3);
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_after_accept: o_ready=%b, required 0", o_ready);
    end
    capture(o);
    e = expect_frame(16'hA5C3, P_DIV + 1);
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL single_frame: got %s; required %s", obs_str(o), obs_str(e));
    end
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_frame: o_ready=%b, required 1", o_ready);
    end
  endtask

  task automatic test_refresh();
    obs_t o, e;
    int   n;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (!o_busy && n < 2 * P_REF) begin
        n++;
        @(negedge clk);
      end
      n_cmp++;
      if (n !== P_REF) begin
        n_bad++;
        $display("FAIL refresh_idle_%0d: idle cycles=%0d, required %0d", r, n, P_REF);
      end
      capture(o);
      e = expect_frame(16'hA5C3, P_DIV);
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL refresh_frame_%0d: got %s; required %s", r, obs_str(o), obs_str(e));
      end
    end
  endtask

  task automatic test_refresh_race();
    obs_t        o, e;
    int          n;
    logic [15:0] d;
    d = 16'($urandom);
    if (d == 16'hA5C3) d = 16'h5A3C;
    n = 0;
    for (int i = 0; i < P_REF; i++) begin
      if (!o_busy) n++;
      if (i == P_REF - 1) begin
        data  = d;
        valid = 1'b1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL race_ready: o_ready=%b, required 1", o_ready);
        end
      end
      @(negedge clk);
    end
    valid = 1'b0;
    while (!o_busy && n < 2 * P_REF) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== P_REF + 1) begin
      n_bad++;
      $display("FAIL race_idle: idle cycles=%0d, required %0d", n, P_REF + 1);
    end
    capture(o);
    e = expect_frame(d, P_DIV + 1);
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL race_frame: got %s; required %s", obs_str(o), obs_str(e));
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2, e1, e2;
    int   low;
    low = 0;
    fork
      begin
        send(16'h0001);
        send(16'hFFFF);
        while (!o_ready && low < 2 * P_BUDGET) begin
          low++;
          @(negedge clk);
        end
      end
      begin
        capture(o1);
        capture(o2);
      end
    join
    // Low from the cycle after the second accept through the second LOAD.
    n_cmp++;
    if (low !== P_FRAME + 1) begin
      n_bad++;
      $display("FAIL b2b_ready_low: cycles=%0d, required %0d", low, P_FRAME + 1);
    end
    e1 = expect_frame(16'h0001, P_DIV + 1);
    e2 = expect_frame(16'hFFFF, P_DIV + 1);
    n_cmp++;
    if (o1 !== e1) begin
      n_bad++;
      $display("FAIL b2b_first: got %s; required %s", obs_str(o1), obs_str(e1));
    end
    n_cmp++;
    if (o2 !== e2) begin
      n_bad++;
      $display("FAIL b2b_second: got %s; required %s", obs_str(o2), obs_str(e2));
    end
  endtask

  task automatic test_random_frames();
    obs_t        o, e;
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(d);
      capture(o);
      e = expect_frame(d, P_DIV + 1);
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL random_frame_%0d: got %s; required %s", i, obs_str(o), obs_str(e));
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    obs_t        o, e;
    logic [15:0] d;
    logic        prev;
    int          rises, w, hi;
    send(16'hF0F0);
    prev  = 1'b0;
    rises = 0;
    w     = 0;
    while (rises < 7 && w < P_BUDGET) begin
      @(negedge clk);
      w++;
      if (o_clk && !prev) rises++;
      prev = o_clk;
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rises !== 7 || {o_clk, o_dai, o_lat, o_busy, o_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_mid_shift: rises=%0d clk/dai/lat/busy/ready=%b, required 7 and 00001",
               rises, {o_clk, o_dai, o_lat, o_busy, o_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < P_REF + 100; i++) begin
      @(negedge clk);
      if (o_busy) hi++;
    end
    n_cmp++;
    if (hi !== 0) begin
      n_bad++;
      $display("FAIL no_refresh_after_reset: busy cycles=%0d, required 0", hi);
    end
    d = 16'($urandom);
    send(d);
    capture(o);
    e = expect_frame(d, P_DIV + 1);
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL frame_after_reset: got %s; required %s", obs_str(o), obs_str(e));
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_refresh();
    test_refresh_race();
    test_back_to_back();
    test_random_frames();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
